// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encodings and counter-width helper
package serial_adder_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder (a, b, ci -> s, co)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, LSB first, with start/busy/done handshake
// Ports: clk, rst_n (async active-low); start, a_in, b_in, cin captured on accepted start;
// sum_out/cout registered result; busy in SHIFT/DONE; done one-cycle result-valid pulse.
// SERIAL_ADDER_SUB_EN: adds input sub; sub=1 computes a_in - b_in (cout=1 means no borrow).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0] state, nxt;
  logic [WIDTH-1:0] a_reg, b_reg, acc;
  logic [CW-1:0] cnt;
  logic carry, b_bit, c0, s, co, go, last;
  assign go = state == S_IDLE && start;
  assign last = cnt == LAST;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub_reg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sub_reg <= 1'b0;
    else if (go) sub_reg <= sub;
  // subtract as A + ~B + 1: invert b bits and force the initial carry high
  assign b_bit = b_reg[0] ^ sub_reg;
  assign c0 = sub | cin;
`else
  assign b_bit = b_reg[0];
  assign c0 = cin;
`endif
  fa_cell u_fa (.a(a_reg[0]), .b(b_bit), .ci(carry), .s(s), .co(co));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb
    nxt = state == S_IDLE  ? (start ? S_SHIFT : S_IDLE) :
          state == S_SHIFT ? (last ? S_DONE : S_SHIFT) : S_IDLE;
  always_comb begin
    busy = state == S_SHIFT || state == S_DONE;
    done = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else if (go) begin
      a_reg <= a_in;
      b_reg <= b_in;
      carry <= c0;
      cnt   <= '0;
    end else if (state == S_SHIFT) begin
      acc   <= {s, acc[WIDTH-1:1]};
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      carry <= co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum_out <= {s, acc[WIDTH-1:1]};
        cout    <= co;
      end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [7:0] a_in = '0, b_in = '0, sum_out;
  logic cout, busy, done;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .sum_out(sum_out), .cout(cout), .busy(busy), .done(done));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                    input logic sb, input logic [7:0] es, input logic ec);
    int d_edge = 0, busy_n = 0, done_n = 0;
    logic partial = 1'b0;
    logic [8:0] prev;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; sub = sb; start = 1'b1;
    prev = {cout, sum_out};
    @(posedge clk); #1;
    start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c; sub = ~sb;
    busy_n += int'(busy);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      busy_n += int'(busy);
      done_n += int'(done);
      if (done && d_edge == 0) d_edge = i + 1;
      if (d_edge == 0 && {cout, sum_out} !== prev) partial = 1'b1;
    end
    chk({tag, "_sum"}, 32'(sum_out), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_done_edge"}, d_edge, 9);
    chk({tag, "_busy_cycles"}, busy_n, 9);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_no_partial"}, 32'(partial), 0);
  endtask
  initial begin
    int dn;
    repeat (2) @(negedge clk);
    chk("rst_sum", 32'(sum_out), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    dn = 0;
    repeat (6) begin @(negedge clk); dn += int'(done) + int'(busy); end
    chk("idle_quiet", dn, 0);
    op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    // reset asserted just after E4 of a run
    @(negedge clk);
    a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum_out), 0);
    chk("abort_cout", 32'(cout), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    dn = 0;
    repeat (3) begin @(negedge clk); dn += int'(done); end
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); dn += int'(done); end
    chk("abort_no_done", dn, 0);
    op("fresh_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    // start held high: A/B changed after E0, second op accepted at E0+10
    @(negedge clk);
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a_in = 8'h01; b_in = 8'h02;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1;
      if (i == 8) begin
        chk("held_done", 32'(done), 1);
        chk("held_sum", 32'(sum_out), 32'h46);
      end
      if (i == 9) chk("held_idle_gap", 32'(busy), 0);
      if (i == 10) begin
        chk("held_reaccept", 32'(busy), 1);
        start = 1'b0;
      end
      if (i == 18) begin
        chk("held2_done", 32'(done), 1);
        chk("held2_sum", 32'(sum_out), 32'h03);
      end
    end
    repeat (2) @(posedge clk);
`ifdef SERIAL_ADDER_SUB_EN
    op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
